// File: rtl/sync_debounce_pkg.sv
// rtl/sync_debounce_pkg.sv - shared sizing helpers for the input conditioner
package sync_debounce_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A one-cycle filter still needs a one-bit counter so the datapath stays uniform.
    function automatic int cnt_width(input int cycles);
        return (clog2(cycles) < 1) ? 1 : clog2(cycles);
    endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// rtl/sync_debounce_channel.sv - one channel: synchronizer, debounce counter, edge pulses, sticky flag
module sync_debounce_channel
    import sync_debounce_pkg::*;
#(
    parameter int   STAGES          = 2,
    parameter int   DEBOUNCE_CYCLES = 8,
    parameter logic RESET_LEVEL_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic clear,
    output logic out,
    output logic rise,
    output logic fall,
    output logic event_sticky
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic              stage0_q, stage0_d;
    logic [STAGES-2:0] chain_q, chain_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              sticky_q, sticky_d;
    logic              s;

    assign s = chain_q[STAGES-2];

    always_comb begin
        stage0_d   = in;
        chain_d    = '0;
        chain_d[0] = stage0_q;
        for (int i = 1; i < STAGES - 1; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    // A new level must survive a full window before it is committed to out.
    always_comb begin
        cnt_d  = '0;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s != out_q) begin
            if (cnt_q == CNT_MAX) begin
                out_d  = s;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        sticky_d = rise_d | fall_d | (sticky_q & ~clear);
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            stage0_q <= RESET_LEVEL_BIT;
        end else begin
            stage0_q <= stage0_d;
        end
    end

    // Chain and out share the reset level so release never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q  <= {(STAGES-1){RESET_LEVEL_BIT}};
            cnt_q    <= '0;
            out_q    <= RESET_LEVEL_BIT;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            chain_q  <= chain_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    assign out          = out_q;
    assign rise         = rise_q;
    assign fall         = fall_q;
    assign event_sticky = sticky_q;

endmodule

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - multi-channel synchronize/debounce/edge-detect input conditioner
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int               WIDTH           = 1,
    parameter int               STAGES          = 2,
    parameter int               DEBOUNCE_CYCLES = 8,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] event_sticky
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_debounce_channel #(
            .STAGES         (STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL_BIT(RESET_LEVEL[i])
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .in          (in[i]),
            .clear       (clear[i]),
            .out         (out[i]),
            .rise        (rise[i]),
            .fall        (fall[i]),
            .event_sticky(event_sticky[i])
        );
    end

endmodule

// File: tb/tb_sync_debounce.sv
// tb/tb_sync_debounce.sv - directed self-checking bench for sync_debounce
module tb_sync_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    logic       rst_rl, in_rl, clear_rl, out_rl, rise_rl, fall_rl, sticky_rl;
    logic       rst_d4, in_d4, clear_d4, out_d4, rise_d4, fall_d4, sticky_d4;
    logic       rst_w4;
    logic [3:0] in_w4, clear_w4, out_w4, rise_w4, fall_w4, sticky_w4;

    sync_debounce #(.WIDTH(1), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b1)) dut_rl (
        .clk(clk), .reset(rst_rl), .in(in_rl), .clear(clear_rl),
        .out(out_rl), .rise(rise_rl), .fall(fall_rl), .event_sticky(sticky_rl)
    );

    sync_debounce #(.WIDTH(1), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut_d4 (
        .clk(clk), .reset(rst_d4), .in(in_d4), .clear(clear_d4),
        .out(out_d4), .rise(rise_d4), .fall(fall_d4), .event_sticky(sticky_d4)
    );

    sync_debounce #(.WIDTH(4), .STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(4'b0000)) dut_w4 (
        .clk(clk), .reset(rst_w4), .in(in_w4), .clear(clear_w4),
        .out(out_w4), .rise(rise_w4), .fall(fall_w4), .event_sticky(sticky_w4)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_rl = 1'b1; rst_d4 = 1'b1; rst_w4 = 1'b1;
        in_rl  = 1'b1; in_d4  = 1'b0; in_w4  = 4'b0000;
        clear_rl = 1'b0; clear_d4 = 1'b0; clear_w4 = 4'b0000;
        step();
        step();
        check("rl_reset_out", {3'b0, out_rl}, 4'b0001);
        check("rl_reset_flags", {1'b0, rise_rl, fall_rl, sticky_rl}, 4'b0000);
        check("d4_reset_out", {3'b0, out_d4}, 4'b0000);
        check("d4_reset_sticky", {3'b0, sticky_d4}, 4'b0000);
        check("w4_reset_out", out_w4, 4'b0000);
        rst_rl = 1'b0; rst_d4 = 1'b0; rst_w4 = 1'b0;

        // Reset level 1 with input held high: nothing should move.
        for (int i = 0; i < 6; i++) begin
            step();
            check("rl_release_out", {3'b0, out_rl}, 4'b0001);
            check("rl_release_flags", {1'b0, rise_rl, fall_rl, sticky_rl}, 4'b0000);
        end

        // Three-cycle glitch is filtered.
        in_d4 = 1'b1;
        step(); step(); step();
        in_d4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("glitch_out", {3'b0, out_d4}, 4'b0000);
            check("glitch_flags", {1'b0, rise_d4, fall_d4, sticky_d4}, 4'b0000);
        end

        // Rising change: out and rise at k+4.
        in_d4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rise_wait_out", {3'b0, out_d4}, 4'b0000);
            check("rise_wait_rise", {3'b0, rise_d4}, 4'b0000);
        end
        step();
        check("rise_out", {3'b0, out_d4}, 4'b0001);
        check("rise_pulse", {1'b0, rise_d4, fall_d4, sticky_d4}, 4'b0101);
        step();
        check("rise_after_out", {3'b0, out_d4}, 4'b0001);
        check("rise_after_pulse", {1'b0, rise_d4, fall_d4, sticky_d4}, 4'b0001);

        // Sticky clear alone, then clear coincident with a falling edge.
        clear_d4 = 1'b1;
        step();
        check("clear_alone", {3'b0, sticky_d4}, 4'b0000);
        clear_d4 = 1'b0;
        in_d4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fall_wait_out", {3'b0, out_d4}, 4'b0001);
        end
        clear_d4 = 1'b1;
        step();
        check("fall_out", {3'b0, out_d4}, 4'b0000);
        check("fall_set_wins", {1'b0, rise_d4, fall_d4, sticky_d4}, 4'b0011);
        clear_d4 = 1'b0;
        step();
        check("fall_after", {1'b0, rise_d4, fall_d4, sticky_d4}, 4'b0001);
        clear_d4 = 1'b1;
        step();
        check("clear_second", {3'b0, sticky_d4}, 4'b0000);
        step();
        check("clear_idle", {out_d4, rise_d4, fall_d4, sticky_d4}, 4'b0000);
        clear_d4 = 1'b0;

        // Reset at cnt=2 of a rising change; release with input still high.
        in_d4 = 1'b1;
        step(); step(); step();
        rst_d4 = 1'b1;
        #1;
        check("midreset_out", {3'b0, out_d4}, 4'b0000);
        step(); step();
        check("midreset_hold", {out_d4, rise_d4, fall_d4, sticky_d4}, 4'b0000);
        rst_d4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("release_wait", {out_d4, rise_d4, fall_d4, sticky_d4}, 4'b0000);
        end
        step();
        check("release_out", {3'b0, out_d4}, 4'b0001);
        check("release_rise", {1'b0, rise_d4, fall_d4, sticky_d4}, 4'b0101);

        // Four channels, three stages, no filter: ch0 and ch3 together.
        in_w4 = 4'b1001;
        step();
        check("w4_k_out", out_w4, 4'b0000);
        step();
        check("w4_k1_out", out_w4, 4'b0000);
        check("w4_k1_rise", rise_w4, 4'b0000);
        step();
        check("w4_k2_out", out_w4, 4'b1001);
        check("w4_k2_rise", rise_w4, 4'b1001);
        check("w4_k2_fall", fall_w4, 4'b0000);
        step();
        check("w4_k3_rise", rise_w4, 4'b0000);
        check("w4_k3_sticky", sticky_w4, 4'b1001);
        check("w4_k3_out", out_w4, 4'b1001);
        in_w4 = 4'b0000;
        step();
        step();
        check("w4_fall_wait", out_w4, 4'b1001);
        step();
        check("w4_fall_out", out_w4, 4'b0000);
        check("w4_fall_pulse", fall_w4, 4'b1001);
        check("w4_fall_rise", rise_w4, 4'b0000);
        step();
        check("w4_fall_after", fall_w4, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
